// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store sequencing controller.
//   - opcode localparams in the core's 6-bit ALU opcode encoding
//   - FSM state enum
//   - helpers: opcode classification, byte enables, write-lane placement,
//     misalignment detection
package lsu_pkg;

    localparam logic [5:0] OP_LB  = 6'd0;
    localparam logic [5:0] OP_LH  = 6'd1;
    localparam logic [5:0] OP_LW  = 6'd2;
    localparam logic [5:0] OP_LBU = 6'd3;
    localparam logic [5:0] OP_LHU = 6'd4;
    localparam logic [5:0] OP_SB  = 6'd15;
    localparam logic [5:0] OP_SH  = 6'd16;
    localparam logic [5:0] OP_SW  = 6'd17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    function automatic logic is_mem_op(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    // Loads always fetch the full word; lane selection happens on the way back.
    function automatic logic [3:0] byte_en(input logic [5:0] op, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (op)
            OP_SB:   be = 4'b0001 << addr_lo;
            OP_SH:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicating the source across lanes lets the byte enables pick the lane.
    function automatic logic [31:0] place_wdata(input logic [5:0] op, input logic [31:0] wdata);
        logic [31:0] w;
        case (op)
            OP_SB:   w = {4{wdata[7:0]}};
            OP_SH:   w = {2{wdata[15:0]}};
            default: w = wdata;
        endcase
        return w;
    endfunction

    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] addr_lo);
        logic half_op;
        logic word_op;
        half_op = op inside {OP_LH, OP_LHU, OP_SH};
        word_op = op inside {OP_LW, OP_SW};
        return (half_op && addr_lo[0]) || (word_op && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load-data formatter.
// Ports:
//   op      in  6  : latched load opcode
//   addr_lo in  2  : byte offset within the word
//   rdata   in  32 : raw word from data memory
//   data    out 32 : selected byte/halfword, sign- or zero-extended (LW passes through)
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = rdata;
        case (op)
            OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data = {24'h000000, byte_sel};
            OP_LH:   data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data = {16'h0000, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencing controller between the execute stage and a
// multi-cycle data memory. One operation in flight; FSM IDLE -> BUSY -> RESP.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned LH/LHU/SH/LW/SW go IDLE -> RESP with err=1, no bus request
//   undefined : no check; low address bits only select lanes
//
// Parameter: TIMEOUT (2..255) - cycles mem_req is held without mem_ack before abort.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   req_valid/op/addr/wdata : operation from the core (held while stall=1)
//   stall                : freezes the core (combinational only in the accept cycle)
//   rsp_valid/rsp_rdata  : one-cycle completion pulse and extended load data
//   err                  : one-cycle error pulse with rsp_valid (timeout/misalign)
//   mem_req/we/be/addr/wdata : registered bus request
//   mem_ack/mem_rdata    : bus completion and read word (same cycle)
//
// Handshake: a request is taken in IDLE when req_valid=1 with a memory opcode;
// the bus transaction completes in the BUSY cycle where mem_req=1 and mem_ack=1;
// rsp_valid is asserted for exactly one cycle (RESP), where stall is low.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    lsu_state_e  state_q, state_d;

    logic [5:0]  op_q, op_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        mem_req_d, mem_we_d, rsp_valid_d, err_d;
    logic [3:0]  mem_be_d;
    logic [31:0] mem_addr_d, mem_wdata_d, rsp_rdata_d;

    logic        accept;
    logic        trap;
    logic        timeout_hit;
    logic [31:0] load_data;

    assign accept      = req_valid && is_mem_op(req_op);
    assign timeout_hit = (cnt_q == CNT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = misaligned(req_op, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    lsu_load_align u_load_align (
        .op      (op_q),
        .addr_lo (addr_lo_q),
        .rdata   (mem_rdata),
        .data    (load_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = trap ? RESP : BUSY;
                end
            end
            BUSY: begin
                // An ack in the last counted cycle still wins over the timeout.
                if (mem_ack || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: stall plus next values of all registered outputs
    always_comb begin
        stall       = 1'b0;
        op_d        = op_q;
        addr_lo_d   = addr_lo_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_be_d    = mem_be;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        rsp_valid_d = 1'b0;
        err_d       = 1'b0;
        rsp_rdata_d = 32'h0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    stall     = 1'b1;
                    op_d      = req_op;
                    addr_lo_d = req_addr[1:0];
                    if (trap) begin
                        rsp_valid_d = 1'b1;
                        err_d       = 1'b1;
                    end else begin
                        cnt_d       = 8'h00;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store(req_op);
                        mem_be_d    = byte_en(req_op, req_addr[1:0]);
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wdata_d = place_wdata(req_op, req_wdata);
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = is_store(op_q) ? 32'h0 : load_data;
                end else if (timeout_hit) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    err_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    // Datapath / output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= 6'h00;
            addr_lo_q <= 2'b00;
            cnt_q     <= 8'h00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'h0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            rsp_valid <= 1'b0;
            err       <= 1'b0;
            rsp_rdata <= 32'h0;
        end else begin
            op_q      <= op_d;
            addr_lo_q <= addr_lo_d;
            cnt_q     <= cnt_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_be    <= mem_be_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            rsp_valid <= rsp_valid_d;
            err       <= err_d;
            rsp_rdata <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed bench for lsu_ctrl with hand-computed expectations.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [5:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    lsu_ctrl #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance into the next cycle; inputs are driven and outputs sampled 1ns+ after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_op    = 6'd0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
    endtask

    // One full transaction with the ack in cycle ack_cycle (>= 1).
    task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int ack_cycle,
                          input logic [3:0] exp_be, input logic [31:0] exp_addr,
                          input logic [31:0] exp_wdata, input logic exp_we,
                          input logic [31:0] exp_rdata);
        tick();
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        #1;
        check_eq({name, ".c0_stall"}, 32'(stall), 32'd1);
        for (int c = 1; c <= ack_cycle; c++) begin
            tick();
            check_eq($sformatf("%s.c%0d_mem_req", name, c), 32'(mem_req), 32'd1);
            check_eq($sformatf("%s.c%0d_stall", name, c), 32'(stall), 32'd1);
            if (c == 1) begin
                check_eq({name, ".mem_be"}, 32'(mem_be), 32'(exp_be));
                check_eq({name, ".mem_addr"}, mem_addr, exp_addr);
                check_eq({name, ".mem_we"}, 32'(mem_we), 32'(exp_we));
                if (exp_we) check_eq({name, ".mem_wdata"}, mem_wdata, exp_wdata);
            end
            if (c == ack_cycle) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
        end
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        check_eq({name, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        check_eq({name, ".rsp_err"}, 32'(err), 32'd0);
        check_eq({name, ".rsp_rdata"}, rsp_rdata, exp_rdata);
        check_eq({name, ".rsp_stall"}, 32'(stall), 32'd0);
        check_eq({name, ".rsp_mem_req"}, 32'(mem_req), 32'd0);
        req_valid = 1'b0;
        tick();
        check_eq({name, ".pulse_end"}, 32'(rsp_valid), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int req_cycles;
        bit seen_resp;

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset.stall", 32'(stall), 32'd0);
        check_eq("reset.mem_req", 32'(mem_req), 32'd0);
        check_eq("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("reset.err", 32'(err), 32'd0);
        check_eq("reset.mem_be", 32'(mem_be), 32'd0);
        check_eq("reset.mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;

        // LB sign extension: byte 3 of 0x80FF0000 is 0x80
        run_op("lb", 6'd0, 32'h103, 32'h0, 32'h80FF_0000, 1, 4'hF, 32'h100, 32'h0, 1'b0, 32'hFFFF_FF80);
        // LHU upper half
        run_op("lhu", 6'd4, 32'h202, 32'h0, 32'hBEEF_1234, 1, 4'hF, 32'h200, 32'h0, 1'b0, 32'h0000_BEEF);
        // SB with ack in cycle 4
        run_op("sb", 6'd15, 32'h301, 32'h0000_00A5, 32'hFFFF_FFFF, 4, 4'h2, 32'h300, 32'hA5A5_A5A5, 1'b1, 32'h0);
        // LH sign extension from the lower half
        run_op("lh", 6'd1, 32'h10, 32'h0, 32'h7777_8001, 2, 4'hF, 32'h10, 32'h0, 1'b0, 32'hFFFF_8001);
        // LBU byte 1, zero extension
        run_op("lbu", 6'd3, 32'h21, 32'h0, 32'h0000_FF00, 1, 4'hF, 32'h20, 32'h0, 1'b0, 32'h0000_00FF);
        // SH upper half
        run_op("sh", 6'd16, 32'h32, 32'hCAFE_1234, 32'h0, 3, 4'hC, 32'h30, 32'h1234_1234, 1'b1, 32'h0);
        // SW full word
        run_op("sw", 6'd17, 32'h44, 32'hDEAD_BEEF, 32'h0, 1, 4'hF, 32'h44, 32'hDEAD_BEEF, 1'b1, 32'h0);

        // Unknown opcode: no stall, no bus request
        tick();
        req_valid = 1'b1;
        req_op    = 6'd5;
        req_addr  = 32'h50;
        #1;
        check_eq("unknown.stall", 32'(stall), 32'd0);
        tick();
        check_eq("unknown.mem_req", 32'(mem_req), 32'd0);
        check_eq("unknown.rsp_valid", 32'(rsp_valid), 32'd0);
        req_valid = 1'b0;

        // Stray ack while idle is ignored
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0;
        check_eq("stray_ack.rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("stray_ack.stall", 32'(stall), 32'd0);

        // Timeout: no ack, mem_req high for exactly 16 cycles
        tick();
        req_valid = 1'b1;
        req_op    = 6'd2;
        req_addr  = 32'h500;
        req_cycles = 0;
        seen_resp  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mem_req) begin
                req_cycles++;
            end else begin
                seen_resp = 1'b1;
                break;
            end
        end
        check_eq("timeout.req_cycles", 32'(req_cycles), 32'd16);
        check_eq("timeout.ended", 32'(seen_resp), 32'd1);
        check_eq("timeout.rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("timeout.err", 32'(err), 32'd1);
        check_eq("timeout.rsp_rdata", rsp_rdata, 32'h0);
        check_eq("timeout.stall", 32'(stall), 32'd0);
        req_valid = 1'b0;
        tick();
        check_eq("timeout.err_pulse_end", 32'(err), 32'd0);

        // Misaligned word
`ifdef LSU_MISALIGN_TRAP_EN
        tick();
        req_valid = 1'b1;
        req_op    = 6'd2;
        req_addr  = 32'h401;
        #1;
        check_eq("misalign.c0_stall", 32'(stall), 32'd1);
        tick();
        check_eq("misalign.rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("misalign.err", 32'(err), 32'd1);
        check_eq("misalign.rsp_rdata", rsp_rdata, 32'h0);
        check_eq("misalign.mem_req", 32'(mem_req), 32'd0);
        check_eq("misalign.stall", 32'(stall), 32'd0);
        req_valid = 1'b0;
        tick();
        check_eq("misalign.mem_req_after", 32'(mem_req), 32'd0);
`else
        run_op("lw_mis", 6'd2, 32'h401, 32'h0, 32'h0BAD_F00D, 1, 4'hF, 32'h400, 32'h0, 1'b0, 32'h0BAD_F00D);
`endif

        // Reset while BUSY
        tick();
        req_valid = 1'b1;
        req_op    = 6'd2;
        req_addr  = 32'h600;
        tick();
        tick();
        check_eq("rst_busy.mem_req_before", 32'(mem_req), 32'd1);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        check_eq("rst_busy.mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_busy.stall", 32'(stall), 32'd0);
        check_eq("rst_busy.rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        run_op("lw_after_rst", 6'd2, 32'h604, 32'h0, 32'h1357_9BDF, 2, 4'hF, 32'h604, 32'h0, 1'b0, 32'h1357_9BDF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
